ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
- Registered operand stage between decode/register-file read and the execute-stage comparator/ALU.
- Applies result forwarding from MEM and WB, and selects the immediate for operand B.
- Buffers one operand bundle (A, B, unsigned flag) in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Output bundle drives the comparator's operand A, operand B and signed/unsigned select directly.

Parameters:
- XLEN, 32, operand width in bits.
- REG_AW, 5, register address width.

Ports:
- I_CLK  in  1  clock, rising edge.
- I_RST_N  in  1  asynchronous active-low reset.
- I_VALID  in  1  upstream bundle valid.
- O_READY  out  1  stage can accept a bundle (registered).
- I_RS1_ADDR  in  REG_AW  source register 1 index.
- I_RS2_ADDR  in  REG_AW  source register 2 index.
- I_RS1_DATA  in  XLEN  register-file read data 1.
- I_RS2_DATA  in  XLEN  register-file read data 2.
- I_IMM  in  XLEN  sign-extended immediate.
- I_USE_IMM  in  1  1: operand B = I_IMM.
- I_U  in  1  1 = unsigned compare (SLTU/SLTIU/BLTU/BGEU).
- I_FLUSH  in  1  kill all buffered bundles.
- I_MEM_WE  in  1  MEM stage writes rd.
- I_MEM_RD  in  REG_AW  MEM stage destination register.
- I_MEM_DATA  in  XLEN  MEM stage result.
- I_WB_WE  in  1  WB stage writes rd.
- I_WB_RD  in  REG_AW  WB stage destination register.
- I_WB_DATA  in  XLEN  WB stage result.
- O_VALID  out  1  output bundle valid.
- I_READY  in  1  downstream accepts bundle.
- O_OP_A  out  XLEN  operand A to comparator/ALU.
- O_OP_B  out  XLEN  operand B to comparator/ALU.
- O_U  out  1  unsigned select to comparator.

Behaviour:
- Clock and reset: single clock I_CLK; reset I_RST_N is asynchronous and active-low.
- Reset values: O_VALID=0, O_READY=1, O_OP_A=0, O_OP_B=0, O_U=0, state EMPTY, skid contents 0.
- Accept and transfer:
  - Accept occurs when I_VALID & O_READY.
  - Output transfer occurs when O_VALID & I_READY.
- Forwarding (combinational, evaluated at the input, before registering):
  - For each source register, a MEM hit is MEM_WE & MEM_RD==rs & rs!=0; otherwise a WB hit is WB_WE & WB_RD==rs & rs!=0; otherwise register-file data is used.
  - MEM has priority over WB.
  - rs=0 always yields the raw register-file data (x0 is never forwarded).
- Operand B: I_IMM when I_USE_IMM=1, otherwise the forwarded rs2 value. I_U passes through with the bundle.
- Latency: accepted bundle appears on the outputs the next cycle. Throughput is 1 bundle per cycle when I_READY is held high.
- State machine (main register M, skid register S):
  - EMPTY: accept -> FULL (load M).
  - FULL, accept with no transfer -> SKID (load S).
  - FULL, transfer with no accept -> EMPTY.
  - FULL, both accept and transfer -> FULL (load M).
  - SKID: O_READY=0. Transfer -> FULL (M<=S). No transfer -> hold.
- O_READY: registered, equal to (next state != SKID).
- Stability: output bundle values stay constant while O_VALID=1 and I_READY=0.
- Flush:
  - Next state is EMPTY, O_VALID=0 next cycle, O_READY=1 next cycle.
  - An accept in the same cycle is dropped.
  - Flush has priority over all other events.
- Reset mid-operation clears all bundles immediately; no partial bundle is emitted.
- Arithmetic: no arithmetic in this block; all widths are exact XLEN with no extension.

Optional Feature:
- Macro: EX_OPERAND_FWD_EN.
- Defined: MEM/WB forwarding as described above.
- Undefined: operands come directly from I_RS1_DATA/I_RS2_DATA (or I_IMM). Forwarding ports are unused, and the pipeline relies on stall-based hazard handling upstream.

Decomposition:
- Package riscv_ex_pkg holds:
  - XLEN and REG_AW constants.
  - typedef operand_bundle_t {op_a, op_b, u}.
  - typedef enum opst_e {ST_EMPTY, ST_FULL, ST_SKID}.
- Sub-module fwd_sel: one source-register forwarding select (address, rf data, MEM/WB taps -> operand). Instantiated twice.

Test Plan:
- Reset, then I_VALID=1 with RS1=5/0x0000_0010 and RS2=6/0xFFFF_FFF0, I_U=0 -> next cycle O_VALID=1, O_OP_A=0x10, O_OP_B=0xFFFF_FFF0, O_U=0.
- RS1_ADDR=3, MEM_WE=1/MEM_RD=3/MEM_DATA=0xAAAA_0001 and WB_WE=1/WB_RD=3/WB_DATA=0x5555 -> O_OP_A=0xAAAA_0001. Same with RS1_ADDR=0 -> raw RS1_DATA. With macro undefined -> raw RS1_DATA.
- I_READY=0 for 3 cycles while sending bundles B1, B2 -> O_READY drops after B2; B3 is not accepted. I_READY=1 -> B1, B2, B3 delivered in order, no loss or duplication.
- State SKID plus I_FLUSH=1 together with I_VALID=1 -> next cycle O_VALID=0, O_READY=1; neither the flushed bundles nor the incoming bundle ever appear.
- I_USE_IMM=1, I_IMM=0xFFFF_F800, I_U=1 -> O_OP_B=0xFFFF_F800, O_U=1, rs2 forwarding ignored.
- I_RST_N asserted low mid-stream in state FULL -> O_VALID=0 immediately (asynchronously), O_READY=1 after release.

Source files
------------

// File: rtl/riscv_ex_pkg.sv
// Shared constants and types for the execute-stage operand path.
// Used by ex_operand_stage and fwd_sel.
package riscv_ex_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            u;
  } operand_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } opst_e;

endpackage

// File: rtl/fwd_sel.sv
// One source-register operand select: MEM result, else WB result, else register file.
// Forwarding exists only when EX_OPERAND_FWD_EN is defined; otherwise the rf data passes straight through.
module fwd_sel #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   operand
);

`ifdef EX_OPERAND_FWD_EN
  // x0 is hard-wired zero in the register file, so it is never forwarded.
  always_comb begin
    operand = rf_data;
    if (rs_addr != '0) begin
      if (mem_we && (mem_rd == rs_addr)) begin
        operand = mem_data;
      end else if (wb_we && (wb_rd == rs_addr)) begin
        operand = wb_data;
      end
    end
  end
`else
  logic unused_taps;
  assign unused_taps = ^{rs_addr, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data};
  assign operand     = rf_data;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// Registered operand stage: forwarding/immediate select feeding a 2-entry skid buffer.
// Optional MEM/WB forwarding is enabled with the EX_OPERAND_FWD_EN macro.
module ex_operand_stage
  import riscv_ex_pkg::*;
(
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VALID,
  output logic              O_READY,
  input  logic [REG_AW-1:0] I_RS1_ADDR,
  input  logic [REG_AW-1:0] I_RS2_ADDR,
  input  logic [XLEN-1:0]   I_RS1_DATA,
  input  logic [XLEN-1:0]   I_RS2_DATA,
  input  logic [XLEN-1:0]   I_IMM,
  input  logic              I_USE_IMM,
  input  logic              I_U,
  input  logic              I_FLUSH,
  input  logic              I_MEM_WE,
  input  logic [REG_AW-1:0] I_MEM_RD,
  input  logic [XLEN-1:0]   I_MEM_DATA,
  input  logic              I_WB_WE,
  input  logic [REG_AW-1:0] I_WB_RD,
  input  logic [XLEN-1:0]   I_WB_DATA,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [XLEN-1:0]   O_OP_A,
  output logic [XLEN-1:0]   O_OP_B,
  output logic              O_U,
  output opst_e             O_STATE
);

  // Handshake: a bundle moves on a rising edge only when its valid and the
  // receiver's ready are both high; valid never depends on ready, and the
  // offered bundle holds steady until it moves.

  logic [XLEN-1:0] rs1_val, rs2_val;
  operand_bundle_t in_b, m_q, m_d, s_q, s_d;
  opst_e           state_q, state_d;
  logic            ready_q;
  logic            accept, xfer;

  fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr (I_RS1_ADDR), .rf_data (I_RS1_DATA),
    .mem_we  (I_MEM_WE),   .mem_rd  (I_MEM_RD),   .mem_data (I_MEM_DATA),
    .wb_we   (I_WB_WE),    .wb_rd   (I_WB_RD),    .wb_data  (I_WB_DATA),
    .operand (rs1_val)
  );

  fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr (I_RS2_ADDR), .rf_data (I_RS2_DATA),
    .mem_we  (I_MEM_WE),   .mem_rd  (I_MEM_RD),   .mem_data (I_MEM_DATA),
    .wb_we   (I_WB_WE),    .wb_rd   (I_WB_RD),    .wb_data  (I_WB_DATA),
    .operand (rs2_val)
  );

  always_comb begin
    in_b.op_a = rs1_val;
    in_b.op_b = I_USE_IMM ? I_IMM : rs2_val;
    in_b.u    = I_U;
  end

  assign O_VALID = (state_q != ST_EMPTY);
  assign O_READY = ready_q;
  assign O_OP_A  = m_q.op_a;
  assign O_OP_B  = m_q.op_b;
  assign O_U     = m_q.u;
  assign O_STATE = state_q;

  assign accept = I_VALID & ready_q;
  assign xfer   = O_VALID & I_READY;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (I_FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            m_d     = in_b;
          end
        end
        ST_FULL: begin
          if (accept && xfer) begin
            m_d = in_b;
          end else if (accept) begin
            state_d = ST_SKID;
            s_d     = in_b;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (xfer) begin
            state_d = ST_FULL;
            m_d     = s_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_SKID);
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule
